tx_arbiter: RTL and testbench

Round-robin scheduler that shares one Dataflow_Tx serial transmitter among N_REQ requesters. It accepts one byte per valid/ready handshake and holds the byte stable on D. It then issues a single-cycle start_sig and times the frame by counting cycles, because the transmitter exposes no busy flag. It sits between the client blocks and the Dataflow_Tx instance; start_sig and D connect directly to it.

---
 rtl/tx_arb_pkg.sv | 20 ++
 rtl/tx_arbiter_rr.sv | 36 +++
 rtl/tx_arbiter.sv | 132 +++++++++++++
 tb/tb_tx_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types, defaults and helpers for the Dataflow_Tx round-robin arbiter.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int unsigned DATA_W           = 8;
  localparam int unsigned FRAME_CYCLES_DEF = 11;
  localparam int unsigned GAP_W            = 4;

  // Index width that stays at least one bit for a single-entry pool.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr_i wins.
module rr_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             any_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Scan requesters in priority order starting at the pointer, wrapping at N_REQ.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr_i) + i) % N_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin scheduler feeding one Dataflow_Tx; frames are timed by cycle count.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned  n            = DATA_W,
  parameter int unsigned  N_REQ        = 4,
  parameter int unsigned  FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned  GAP_CYCLES   = 0,
  localparam int unsigned ID_W         = clog2_min1(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*n-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               start_sig,
  output logic [n-1:0]       D,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned      CNT_W    = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [n-1:0]      data_q, data_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              start_q, busy_q, done_q;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              any;
  logic [n-1:0]      data_arr [N_REQ];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i    (req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (any)
  );

  // Unpack the flat request bus so the winner's byte is a plain index.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*n +: n];
  end

  // Next-state, counters and the combinational accept strobe (held low in reset).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    gid_d     = gid_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (en && any && rst_n) begin
          req_ready = gnt;
          data_d    = data_arr[gnt_id];
          gid_d     = gnt_id;
          ptr_d     = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
          state_d   = START;
        end
      end
      START: begin
        cnt_d   = CNT_W'(1);
        state_d = SEND;
      end
      SEND: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          gap_d = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs decode the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      start_q <= (state_d == START);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == SEND) && (cnt_d == CNT_LAST);
    end
  end

  assign start_sig  = start_q;
  assign D          = data_q;
  assign grant_id   = gid_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Scoreboard bench for tx_arbiter: timeline reference model predicts accepts, starts and frame ends.
module tb_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int FC    = 11;
  localparam int GAP   = 0;
  localparam int GAP_G = 3;
  localparam int IW    = 2;
  localparam int DBW   = 5;

  typedef struct {
    int          cyc;
    int          id;
    logic [W-1:0] data;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     req_ready;
  logic             start_sig;
  logic [W-1:0]     D;
  logic [IW-1:0]    grant_id;
  logic             busy;
  logic             frame_done;

  logic             g_en = 1'b1;
  logic [N-1:0]     g_valid = '0;
  logic [N*W-1:0]   g_data = '0;
  logic [N-1:0]     g_ready;
  logic             g_start;
  logic [W-1:0]     g_D;
  logic [IW-1:0]    g_gid;
  logic             g_busy;
  logic             g_done;

  int checks = 0;
  int failures = 0;

  // Reference model state (timeline view of the scheduler).
  int  cyc = 0;
  int  m_ptr = 0;
  int  m_free = 0;
  int  m_last = -1000;
  ev_t q_acc[$];
  ev_t q_start[$];
  int  q_done[$];
  ev_t s_log[$];

  always #5 clk = ~clk;

  tx_arbiter #(.n(W), .N_REQ(N), .FRAME_CYCLES(FC), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .start_sig(start_sig), .D(D), .grant_id(grant_id),
    .busy(busy), .frame_done(frame_done)
  );

  tx_arbiter #(.n(W), .N_REQ(N), .FRAME_CYCLES(FC), .GAP_CYCLES(GAP_G)) dut_g (
    .clk(clk), .rst_n(rst_n), .en(g_en), .req_valid(g_valid), .req_data(g_data),
    .req_ready(g_ready), .start_sig(g_start), .D(g_D), .grant_id(g_gid),
    .busy(g_busy), .frame_done(g_done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: each cycle, if the channel is free and enabled, the first valid requester from ptr wins.
  initial begin : model
    ev_t e;
    int  w;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (!rst_n) begin
        q_acc.delete(); q_start.delete(); q_done.delete();
        m_ptr = 0; m_free = 0; m_last = -1000;
      end else if (cyc >= m_free && en && (req_valid != '0)) begin
        w = -1;
        for (int i = 0; i < N; i++)
          if (w < 0 && req_valid[IW'((m_ptr + i) % N)]) w = (m_ptr + i) % N;
        e.cyc = cyc; e.id = w; e.data = req_data[DBW'(w * W) +: W];
        q_acc.push_back(e);
        e.cyc = cyc + 1;
        q_start.push_back(e);
        q_done.push_back(cyc + FC);
        m_ptr  = (w + 1) % N;
        m_free = cyc + FC + GAP + 1;
        m_last = cyc;
      end
    end
  end

  // Monitor: compare DUT outputs against the model's queued expectations, mid-cycle.
  initial begin : monitor
    ev_t e;
    bit  exp_now;
    bit  exp_busy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_now = (q_acc.size() > 0) && (q_acc[0].cyc == cyc);
        if ((req_ready != '0) || exp_now) begin
          chk("accept_present", 64'(req_ready != '0), 64'(exp_now));
          if (exp_now) begin
            e = q_acc.pop_front();
            if (req_ready != '0) chk("accept_ready_vector", 64'(req_ready), 64'(N'(1) << e.id));
          end
        end
        exp_now = (q_start.size() > 0) && (q_start[0].cyc == cyc);
        if (start_sig || exp_now) begin
          chk("start_sig", 64'(start_sig), 64'(exp_now));
          if (exp_now) begin
            e = q_start.pop_front();
            if (start_sig) begin
              chk("D_at_start", 64'(D), 64'(e.data));
              chk("grant_id_at_start", 64'(grant_id), 64'(e.id));
            end
          end
        end
        if (start_sig) begin
          e.cyc = cyc; e.id = int'(grant_id); e.data = D;
          s_log.push_back(e);
        end
        exp_now = (q_done.size() > 0) && (q_done[0] == cyc);
        if (frame_done || exp_now) begin
          chk("frame_done", 64'(frame_done), 64'(exp_now));
          if (exp_now) void'(q_done.pop_front());
        end
        exp_busy = (cyc > m_last) && (cyc <= m_last + FC + GAP);
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
        chk("ready_without_valid", 64'(req_ready & ~req_valid), 64'(0));
      end
    end
  end

  // One bus cycle: sample handshakes mid-cycle, retire accepted requests after the edge.
  task automatic tick(output logic [N-1:0] acc);
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_start_sig"}, 64'(start_sig), 64'(0));
    chk({tag, "_D"}, 64'(D), 64'(0));
    chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  initial begin : stim
    logic [N-1:0] acc;
    logic [N-1:0] gacc;
    logic [W-1:0] exp_b;
    int t0, t1, td, n3, waited;
    bit busy_ok;
    logic [W-1:0] d0, d1;
    logic [IW-1:0] id0, id1;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    en = 1'b1;

    // Single request from requester 1.
    req_data[DBW'(1 * W) +: W] = 8'h55;
    req_valid[1] = 1'b1;
    repeat (20) tick(acc);
    chk("single_log_count", 64'(s_log.size()), 64'(1));
    if (s_log.size() > 0) begin
      chk("single_grant_id", 64'(s_log[0].id), 64'(1));
      chk("single_byte", 64'(s_log[0].data), 64'(8'h55));
    end
    chk("single_busy_after", 64'(busy), 64'(0));
    chk("single_D_holds", 64'(D), 64'(8'h55));

    // All four continuously valid from reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_log.delete();
    for (int i = 0; i < N; i++) req_data[DBW'(i * W) +: W] = 8'hA0 + 8'(i);
    req_valid = '1;
    for (int c = 0; c < 60; c++) begin
      tick(acc);
      req_valid = req_valid | acc;
    end
    req_valid = '0;
    chk("rr_log_at_least_5", 64'(s_log.size() >= 5), 64'(1));
    if (s_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        exp_b = 8'hA0 + 8'(k % 4);
        chk("rr_order_id", 64'(s_log[k].id), 64'(k % 4));
        chk("rr_order_byte", 64'(s_log[k].data), 64'(exp_b));
        if (k > 0) chk("rr_start_spacing", 64'(s_log[k].cyc - s_log[k-1].cyc), 64'(12));
      end
    end
    repeat (15) tick(acc);

    // Enable low blocks grants; then enable, and drop it mid-frame.
    s_log.delete();
    en = 1'b0;
    req_data[DBW'(2 * W) +: W] = 8'h3C;
    req_valid[2] = 1'b1;
    repeat (20) tick(acc);
    chk("en_low_no_start", 64'(s_log.size()), 64'(0));
    chk("en_low_still_pending", 64'(req_valid[2]), 64'(1));
    en = 1'b1;
    tick(acc);
    chk("en_high_accept_immediate", 64'(acc), 64'(4'b0100));
    repeat (4) tick(acc);
    en = 1'b0;
    repeat (12) tick(acc);
    en = 1'b1;

    // Asynchronous reset during the fifth SEND cycle.
    req_data[DBW'(2 * W) +: W] = 8'h77;
    req_valid[2] = 1'b1;
    acc = '0;
    waited = 0;
    while (acc == '0 && waited < 5) begin
      tick(acc);
      waited++;
    end
    chk("pre_reset_accept_req2", 64'(acc), 64'(4'b0100));
    req_data[DBW'(1 * W) +: W] = 8'h11;
    req_data[DBW'(3 * W) +: W] = 8'h33;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    repeat (5) tick(acc);
    chk("pre_reset_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_log.delete();
    repeat (30) tick(acc);
    chk("post_reset_log_nonempty", 64'(s_log.size() > 0), 64'(1));
    if (s_log.size() > 0) chk("post_reset_first_grant", 64'(s_log[0].id), 64'(1));

    // Requester 3 withdraws while the channel is busy.
    req_valid = '0;
    req_data[DBW'(0 * W) +: W] = 8'h0F;
    req_valid[0] = 1'b1;
    acc = '0;
    waited = 0;
    while (acc == '0 && waited < 5) begin
      tick(acc);
      waited++;
    end
    req_data[DBW'(3 * W) +: W] = 8'hEE;
    req_valid[3] = 1'b1;
    repeat (3) tick(acc);
    chk("withdraw_while_busy", 64'(busy), 64'(1));
    req_valid[3] = 1'b0;
    s_log.delete();
    repeat (25) tick(acc);
    n3 = 0;
    foreach (s_log[k]) if (s_log[k].id == 3) n3++;
    chk("withdrawn_never_granted", 64'(n3), 64'(0));

    // Randomized traffic with enable toggling and requester 3 withdrawals.
    for (int c = 0; c < 1500; c++) begin
      tick(acc);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[IW'(i)] && $urandom_range(3) == 0) begin
          req_data[DBW'(i * W) +: W] = W'($urandom);
          req_valid[IW'(i)] = 1'b1;
        end
      end
      if (req_valid[3] && busy && $urandom_range(7) == 0) req_valid[3] = 1'b0;
      en = ($urandom_range(9) != 0);
    end
    req_valid = '0;
    en = 1'b1;
    repeat (FC + 5) tick(acc);
    chk("pending_accepts", 64'(q_acc.size()), 64'(0));
    chk("pending_starts", 64'(q_start.size()), 64'(0));
    chk("pending_dones", 64'(q_done.size()), 64'(0));

    // Gap instance: two back-to-back requests.
    g_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    g_valid = 4'b0011;
    t0 = -1; t1 = -1; td = -1; busy_ok = 1'b1;
    d0 = '0; d1 = '0; id0 = '0; id1 = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      gacc = g_valid & g_ready;
      if (g_start && t0 < 0) begin
        t0 = c; d0 = g_D; id0 = g_gid;
      end else if (g_start && t1 < 0) begin
        t1 = c; d1 = g_D; id1 = g_gid;
      end
      if (g_done && td < 0) td = c;
      if (t0 >= 0 && c <= t0 + FC + GAP_G - 1 && !g_busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      g_valid = g_valid & ~gacc;
    end
    chk("gap_start_spacing", 64'(t1 - t0), 64'(FC + GAP_G + 1));
    chk("gap_busy_through_gap", 64'(busy_ok), 64'(1));
    chk("gap_done_offset", 64'(td - t0), 64'(FC - 1));
    chk("gap_first_byte", 64'(d0), 64'(8'hB0));
    chk("gap_second_byte", 64'(d1), 64'(8'hB1));
    chk("gap_first_id", 64'(id0), 64'(0));
    chk("gap_second_id", 64'(id1), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
